// File: rtl/em_acc_wb.sv
// Dual 40-bit accumulator write stage for the E pipeline stage: load/add/sub/clear,
// optional 32-bit saturation, a sticky overflow flag and a 2-entry writeback FIFO.
module em_acc_wb (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [39:0] MACin_E,
    input  logic        mac_vld_E,
    input  logic [1:0]  mac_op_E,
    input  logic        acc_sel_E,
    input  logic        SatMode_E,
    input  logic        wb_en_E,
    input  logic        wb_rdy,
    input  logic        ovf_clr,
    output logic        stall_E,
    output logic [39:0] acc0,
    output logic [39:0] acc1,
    output logic        wb_vld,
    output logic [31:0] wb_data,
    output logic        wb_acc,
    output logic        ovf_flag
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    localparam logic [39:0] SAT_POS = 40'h00_7FFF_FFFF;
    localparam logic [39:0] SAT_NEG = 40'hFF_8000_0000;

    logic [39:0] acc0_q, acc0_d;
    logic [39:0] acc1_q, acc1_d;
    logic        ovf_q, ovf_d;
    logic [32:0] mem_q [2];
    logic [32:0] mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        accept;
    logic        push;
    logic        pop;
    logic [39:0] acc_a;
    logic [39:0] raw;
    logic        raw_ovf;
    logic        sat_hit;
    logic [39:0] fin;

    // Stall depends only on the stored count so it never loops back through the E-stage inputs.
    assign stall_E = cnt_q[1];
    assign accept  = mac_vld_E & ~stall_E;
    assign push    = accept & wb_en_E;
    assign pop     = (cnt_q != 2'd0) & wb_rdy;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        acc_a   = acc_sel_E ? acc1_q : acc0_q;
        raw     = '0;
        raw_ovf = 1'b0;
        case (mac_op_E)
            OP_LOAD: raw = MACin_E;
            OP_ADD: begin
                raw     = acc_a + MACin_E;
                raw_ovf = (acc_a[39] == MACin_E[39]) && (raw[39] != acc_a[39]);
            end
            OP_SUB: begin
                raw     = acc_a - MACin_E;
                raw_ovf = (acc_a[39] != MACin_E[39]) && (raw[39] != acc_a[39]);
            end
            OP_CLR:  raw = '0;
            default: raw = '0;
        endcase
        // NOTE: blocking assignments here are intended; raw is read back later in the same combinational block.
        sat_hit = SatMode_E && !((&raw[39:31]) || (~|raw[39:31]));
        if (sat_hit) fin = raw[39] ? SAT_NEG : SAT_POS;
        else         fin = raw;
    end

    always_comb begin
        acc0_d = acc0_q;
        acc1_d = acc1_q;
        if (accept) begin
            if (acc_sel_E) acc1_d = fin;
            else           acc0_d = fin;
        end

        if (accept && raw_ovf) ovf_d = 1'b1;
        else if (ovf_clr)      ovf_d = 1'b0;
        else                   ovf_d = ovf_q;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = {acc_sel_E, fin[31:0]};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: the two FIFO slots are reset along with the pointers so wb_data/wb_acc read zero out of reset; flops use <= only.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc0_q   <= '0;
            acc1_q   <= '0;
            ovf_q    <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            acc0_q   <= acc0_d;
            acc1_q   <= acc1_d;
            ovf_q    <= ovf_d;
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign acc0              = acc0_q;
    assign acc1              = acc1_q;
    assign ovf_flag          = ovf_q;
    assign wb_vld            = (cnt_q != 2'd0);
    assign {wb_acc, wb_data} = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_em_acc_wb.sv
// Directed bench for em_acc_wb: accumulate, saturation, overflow, backpressure,
// FIFO ordering and asynchronous reset, with hand-computed expected values.
module tb_em_acc_wb;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [39:0] MACin_E;
    logic        mac_vld_E;
    logic [1:0]  mac_op_E;
    logic        acc_sel_E;
    logic        SatMode_E;
    logic        wb_en_E;
    logic        wb_rdy;
    logic        ovf_clr;
    logic        stall_E;
    logic [39:0] acc0;
    logic [39:0] acc1;
    logic        wb_vld;
    logic [31:0] wb_data;
    logic        wb_acc;
    logic        ovf_flag;

    int errors = 0;
    int checks = 0;

    em_acc_wb dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .MACin_E   (MACin_E),
        .mac_vld_E (mac_vld_E),
        .mac_op_E  (mac_op_E),
        .acc_sel_E (acc_sel_E),
        .SatMode_E (SatMode_E),
        .wb_en_E   (wb_en_E),
        .wb_rdy    (wb_rdy),
        .ovf_clr   (ovf_clr),
        .stall_E   (stall_E),
        .acc0      (acc0),
        .acc1      (acc1),
        .wb_vld    (wb_vld),
        .wb_data   (wb_data),
        .wb_acc    (wb_acc),
        .ovf_flag  (ovf_flag)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [39:0] observed, input logic [39:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
        end
    endtask

    task automatic set_op(input logic vld, input logic [1:0] op, input logic sel,
                          input logic [39:0] din, input logic sat, input logic wben);
        mac_vld_E = vld;
        mac_op_E  = op;
        acc_sel_E = sel;
        MACin_E   = din;
        SatMode_E = sat;
        wb_en_E   = wben;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N   = 1'b0;
        wb_rdy  = 1'b0;
        ovf_clr = 1'b0;
        set_op(1'b0, 2'b00, 1'b0, 40'h0, 1'b0, 1'b0);
        #12;
        check("rst_acc0", acc0, 40'h0);
        check("rst_acc1", acc1, 40'h0);
        check("rst_wb_vld", {39'h0, wb_vld}, 40'h0);
        check("rst_stall", {39'h0, stall_E}, 40'h0);
        check("rst_ovf", {39'h0, ovf_flag}, 40'h0);
        check("rst_wb_data", {8'h0, wb_data}, 40'h0);

        // Accumulate sequence; first op lands on the first edge after reset release.
        @(negedge CLK);
        RST_N = 1'b1;
        set_op(1'b1, 2'b00, 1'b0, 40'h00_0000_0010, 1'b0, 1'b0);
        step();
        check("acc_load", acc0, 40'h00_0000_0010);
        set_op(1'b1, 2'b01, 1'b0, 40'h00_0000_0005, 1'b0, 1'b0);
        step();
        check("acc_add", acc0, 40'h00_0000_0015);
        set_op(1'b1, 2'b10, 1'b0, 40'h00_0000_0020, 1'b0, 1'b0);
        step();
        check("acc_sub", acc0, 40'hFF_FFFF_FFF5);
        check("acc_sub_acc1", acc1, 40'h0);
        check("acc_sub_ovf", {39'h0, ovf_flag}, 40'h0);

        // Saturation into A1 with writeback.
        set_op(1'b1, 2'b00, 1'b1, 40'h00_7FFF_FFF0, 1'b0, 1'b0);
        step();
        check("sat_load", acc1, 40'h00_7FFF_FFF0);
        set_op(1'b1, 2'b01, 1'b1, 40'h00_0000_0020, 1'b1, 1'b1);
        step();
        check("sat_acc1", acc1, 40'h00_7FFF_FFFF);
        check("sat_wb_vld", {39'h0, wb_vld}, 40'h1);
        check("sat_wb_data", {8'h0, wb_data}, 40'h00_7FFF_FFFF);
        check("sat_wb_acc", {39'h0, wb_acc}, 40'h1);
        check("sat_ovf", {39'h0, ovf_flag}, 40'h0);
        check("sat_acc0_hold", acc0, 40'hFF_FFFF_FFF5);
        set_op(1'b0, 2'b00, 1'b0, 40'h0, 1'b0, 1'b0);
        wb_rdy = 1'b1;
        step();
        check("sat_drain", {39'h0, wb_vld}, 40'h0);
        wb_rdy = 1'b0;

        // 40-bit overflow, then set-wins-over-clear, then plain clear.
        set_op(1'b1, 2'b00, 1'b0, 40'h7F_FFFF_FFFF, 1'b0, 1'b0);
        step();
        set_op(1'b1, 2'b01, 1'b0, 40'h00_0000_0001, 1'b0, 1'b0);
        step();
        check("ovf_acc0", acc0, 40'h80_0000_0000);
        check("ovf_set", {39'h0, ovf_flag}, 40'h1);
        set_op(1'b1, 2'b01, 1'b0, 40'h80_0000_0000, 1'b0, 1'b0);
        ovf_clr = 1'b1;
        step();
        check("ovf_set_wins", {39'h0, ovf_flag}, 40'h1);
        check("ovf_wrap_acc0", acc0, 40'h0);
        set_op(1'b0, 2'b00, 1'b0, 40'h0, 1'b0, 1'b0);
        step();
        check("ovf_cleared", {39'h0, ovf_flag}, 40'h0);
        ovf_clr = 1'b0;

        // Backpressure: two pushes fill the FIFO, the third op is held.
        set_op(1'b1, 2'b00, 1'b0, 40'h00_0000_0100, 1'b0, 1'b1);
        step();
        check("bp_push1_acc0", acc0, 40'h00_0000_0100);
        check("bp_push1_stall", {39'h0, stall_E}, 40'h0);
        set_op(1'b1, 2'b01, 1'b0, 40'h00_0000_0001, 1'b0, 1'b1);
        step();
        check("bp_push2_acc0", acc0, 40'h00_0000_0101);
        check("bp_push2_stall", {39'h0, stall_E}, 40'h1);
        set_op(1'b1, 2'b01, 1'b0, 40'h00_0000_0050, 1'b0, 1'b1);
        step();
        check("bp_held_acc0", acc0, 40'h00_0000_0101);
        check("bp_held_acc1", acc1, 40'h00_7FFF_FFFF);
        check("bp_held_stall", {39'h0, stall_E}, 40'h1);
        check("bp_head_stable", {8'h0, wb_data}, 40'h00_0000_0100);
        step();
        check("bp_head_stable2", {8'h0, wb_data}, 40'h00_0000_0100);
        check("bp_acc0_still", acc0, 40'h00_0000_0101);
        wb_rdy = 1'b1;
        step();
        check("bp_pop1_data", {8'h0, wb_data}, 40'h00_0000_0101);
        check("bp_pop1_stall", {39'h0, stall_E}, 40'h0);
        check("bp_pop1_acc0", acc0, 40'h00_0000_0101);
        step();
        check("bp_pushpop_acc0", acc0, 40'h00_0000_0151);
        check("bp_pushpop_vld", {39'h0, wb_vld}, 40'h1);
        check("bp_pushpop_data", {8'h0, wb_data}, 40'h00_0000_0151);
        check("bp_pushpop_stall", {39'h0, stall_E}, 40'h0);
        set_op(1'b0, 2'b00, 1'b0, 40'h0, 1'b0, 1'b0);
        step();
        check("bp_empty", {39'h0, wb_vld}, 40'h0);
        wb_rdy = 1'b0;

        // No-writeback op accepted while wb_rdy=0, then push+pop at count 1.
        set_op(1'b1, 2'b00, 1'b1, 40'h00_0000_0AAA, 1'b0, 1'b1);
        step();
        check("nowb_head", {7'h0, wb_acc, wb_data}, 40'h01_0000_0AAA);
        set_op(1'b1, 2'b01, 1'b1, 40'h00_0000_0005, 1'b0, 1'b0);
        step();
        check("nowb_acc1", acc1, 40'h00_0000_0AAF);
        check("nowb_stall", {39'h0, stall_E}, 40'h0);
        check("nowb_head_kept", {7'h0, wb_acc, wb_data}, 40'h01_0000_0AAA);
        wb_rdy = 1'b1;
        set_op(1'b1, 2'b00, 1'b0, 40'h00_0000_0077, 1'b0, 1'b1);
        step();
        check("pp_acc0", acc0, 40'h00_0000_0077);
        check("pp_vld", {39'h0, wb_vld}, 40'h1);
        check("pp_head", {7'h0, wb_acc, wb_data}, 40'h00_0000_0077);
        check("pp_stall", {39'h0, stall_E}, 40'h0);
        wb_rdy = 1'b0;

        // Fill the FIFO, then reset asynchronously mid-cycle with an op in flight.
        set_op(1'b1, 2'b00, 1'b1, 40'h00_0000_0123, 1'b0, 1'b1);
        step();
        check("prerst_stall", {39'h0, stall_E}, 40'h1);
        check("prerst_acc1", acc1, 40'h00_0000_0123);
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_acc0", acc0, 40'h0);
        check("arst_acc1", acc1, 40'h0);
        check("arst_wb_vld", {39'h0, wb_vld}, 40'h0);
        check("arst_stall", {39'h0, stall_E}, 40'h0);
        check("arst_wb", {7'h0, wb_acc, wb_data}, 40'h0);
        check("arst_ovf", {39'h0, ovf_flag}, 40'h0);

        @(negedge CLK);
        RST_N  = 1'b1;
        wb_rdy = 1'b1;
        set_op(1'b1, 2'b00, 1'b0, 40'h00_0000_0042, 1'b0, 1'b0);
        step();
        check("post_rst_acc0", acc0, 40'h00_0000_0042);
        check("post_rst_no_stale", {39'h0, wb_vld}, 40'h0);
        set_op(1'b0, 2'b00, 1'b0, 40'h0, 1'b0, 1'b0);
        step();
        check("post_rst_still_empty", {39'h0, wb_vld}, 40'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
